// File: rtl/vending_ctrl_multi.sv
// Multi-item vending controller: one-hot coin credit, per-slot stock, single-price vend
// with dispenser handshake, and greedy quarter/dime/nickel change or refund payout.
module vending_ctrl_multi #(
  parameter int unsigned PRICE      = 150,
  parameter int unsigned MAX_CREDIT = 250,
  parameter int unsigned N_ITEMS    = 6,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 15,
  parameter int unsigned CREDIT_W   = 9,
  parameter int unsigned SEL_W      = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [4:0]          coin,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  output logic                sel_err,
  input  logic                refund_req,
  input  logic                restock,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [2:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE} state_e;

  localparam int unsigned         SUM_W     = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    MAX_SUM   = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [SEL_W:0]      N_ITEMS_S = (SEL_W+1)'(N_ITEMS);
  localparam logic [STOCK_W-1:0]  INIT_S    = STOCK_W'(INIT_STOCK);
  localparam logic [CREDIT_W-1:0] V_NICKEL  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] V_DIME    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] V_QUARTER = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] V_HALF    = CREDIT_W'(50);
  localparam logic [CREDIT_W-1:0] V_DOLLAR  = CREDIT_W'(100);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_d;
  logic [STOCK_W-1:0]   stock_q [N_ITEMS];
  logic [CREDIT_W-1:0]  coin_val, change_val;
  logic [SUM_W-1:0]     coin_sum;
  logic                 coin_fits, sel_ok, vend_hs, change_hs;
  logic                 coin_taken, sel_accept, sel_refuse, vend_dec, restock_go;
  logic                 coin_reject_d, sel_err_d, vend_valid_d, change_valid_d, busy_d;
  logic [SEL_W-1:0]     vend_item_d;
  logic [2:0]           change_coin_d;

  // Input decode: coin value (0 = malformed), selection eligibility, handshakes
  always_comb begin
    coin_val = '0;
    case (coin)
      5'b00001: coin_val = V_NICKEL;
      5'b00010: coin_val = V_DIME;
      5'b00100: coin_val = V_QUARTER;
      5'b01000: coin_val = V_HALF;
      5'b10000: coin_val = V_DOLLAR;
      default:  coin_val = '0;
    endcase
    change_val = '0;
    case (change_coin)
      3'b100:  change_val = V_QUARTER;
      3'b010:  change_val = V_DIME;
      3'b001:  change_val = V_NICKEL;
      default: change_val = '0;
    endcase
    coin_sum  = SUM_W'(credit) + SUM_W'(coin_val);
    coin_fits = (coin_val != '0) && (coin_sum <= MAX_SUM);
    sel_ok    = ({1'b0, sel} < N_ITEMS_S) && (credit >= PRICE_C) && (stock_q[sel] != '0);
    vend_hs   = vend_valid && vend_ready;
    change_hs = change_valid && change_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath updates; refund beats selection beats coin
  always_comb begin
    state_d    = state_q;
    credit_d   = credit;
    coin_taken = 1'b0;
    sel_accept = 1'b0;
    sel_refuse = 1'b0;
    vend_dec   = 1'b0;
    restock_go = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (refund_req && state_q == ST_CREDIT) begin
          state_d = ST_CHANGE;
        end else if (sel_valid) begin
          if (state_q == ST_CREDIT && sel_ok) begin
            state_d    = ST_VEND;
            sel_accept = 1'b1;
          end else begin
            sel_refuse = 1'b1;
          end
        end else if (coin_valid && coin_fits) begin
          credit_d   = coin_sum[CREDIT_W-1:0];
          state_d    = ST_CREDIT;
          coin_taken = 1'b1;
        end
        restock_go = restock && (state_q == ST_IDLE);
      end
      ST_VEND: begin
        if (vend_hs) begin
          credit_d = credit - PRICE_C;
          vend_dec = 1'b1;
          state_d  = (credit == PRICE_C) ? ST_IDLE : ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        if (change_hs) begin
          credit_d = credit - change_val;
          if (credit == change_val) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    coin_reject_d  = coin_valid && !coin_taken;
    sel_err_d      = sel_refuse;
    vend_valid_d   = (state_d == ST_VEND);
    vend_item_d    = sel_accept ? sel : vend_item;
    change_valid_d = (state_d == ST_CHANGE);
    busy_d         = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    change_coin_d  = 3'b000;
    if (change_valid_d) begin
      if (credit_d >= V_QUARTER)   change_coin_d = 3'b100;
      else if (credit_d >= V_DIME) change_coin_d = 3'b010;
      else                         change_coin_d = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      credit       <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_coin  <= 3'b000;
      busy         <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INIT_S;
    end else begin
      credit       <= credit_d;
      coin_reject  <= coin_reject_d;
      sel_err      <= sel_err_d;
      vend_valid   <= vend_valid_d;
      vend_item    <= vend_item_d;
      change_valid <= change_valid_d;
      change_coin  <= change_coin_d;
      busy         <= busy_d;
      for (int i = 0; i < N_ITEMS; i++) begin
        if (restock_go)
          stock_q[i] <= INIT_S;
        else if (vend_dec && vend_item == SEL_W'(i))
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: doc/vending_ctrl_multi.md
Name: vending_ctrl_multi

Overview:
Parametrised multi-item vending controller with change return. It accepts one-hot coins, accumulates credit and vends one of N_ITEMS products at a common PRICE. It tracks per-item stock and returns change or refunds one coin per handshake using a greedy quarter/dime/nickel sequence. It sits between the coin-acceptor front end and the dispenser/change-hopper actuators.

Parameters:
PRICE, 150, item price in cents; multiple of 5, 5..MAX_CREDIT
MAX_CREDIT, 250, credit ceiling in cents; a coin that would exceed it is rejected
N_ITEMS, 6, number of product slots, >=2
STOCK_W, 4, stock counter width per slot
INIT_STOCK, 15, stock value loaded at reset and on restock, <= 2^STOCK_W-1
CREDIT_W, 9, credit register width; must hold MAX_CREDIT
SEL_W, $clog2(N_ITEMS), item select width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_valid  in  1  coin present this cycle
coin  in  5  one-hot {dollar, half-dollar, quarter, dime, nickel}, bit 4 = dollar
coin_reject  out  1  one-cycle pulse: offered coin not credited
sel_valid  in  1  item selection strobe
sel  in  SEL_W  selected item index
sel_err  out  1  one-cycle pulse: selection refused
refund_req  in  1  return all credit
restock  in  1  reload all stock to INIT_STOCK
vend_valid  out  1  dispense request
vend_item  out  SEL_W  item to dispense, stable while vend_valid
vend_ready  in  1  dispenser accepts
change_valid  out  1  change coin request
change_coin  out  3  one-hot {quarter, dime, nickel}, stable while change_valid
change_ready  in  1  hopper accepts coin
credit  out  CREDIT_W  current credit in cents, registered
sold_out  out  N_ITEMS  bit i high when stock[i]==0
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async, rst_n=0): state IDLE, credit 0, all stock INIT_STOCK, all pulse and valid outputs 0, vend_item 0, change_coin 0, sold_out 0. Reset asserted mid-VEND or mid-CHANGE aborts the operation immediately. Remaining credit is lost and is not refunded.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Coin values: 5, 10, 25, 50, 100. A coin is accepted only in IDLE or CREDIT, with exactly one bit set and credit+value <= MAX_CREDIT. Accepted: credit updates at t+1 and state becomes CREDIT. Otherwise coin_reject=1 at t+1 and credit is unchanged. Coins offered in VEND or CHANGE are rejected.
- Input priority within IDLE/CREDIT, per cycle: refund_req > sel_valid > coin_valid. The lower-priority coin in a collision is rejected. A collided sel_valid is ignored with no sel_err.
- refund_req in CREDIT moves to CHANGE. It is ignored in IDLE, VEND and CHANGE.
- sel_valid in CREDIT is accepted when credit>=PRICE, sel<N_ITEMS and stock[sel]>0: the machine moves to VEND with vend_item=sel. In any other case sel_err=1 at t+1 and state is unchanged. sel_valid in IDLE also produces sel_err.
- VEND: vend_valid=1 from the next cycle, held until vend_ready. On the handshake cycle stock[vend_item] decrements and credit decreases by PRICE. The next state is CHANGE if the remainder is >0, else IDLE. vend_valid deasserts the cycle after the handshake.
- CHANGE: change_valid=1 with greedy selection: quarter if credit>=25, else dime if >=10, else nickel. The coin is held stable until change_ready. On each handshake credit decreases by the coin value. When credit reaches 0 the machine goes to IDLE and change_valid drops. One coin is issued per handshake, and back-to-back handshakes are permitted.
- Credit is always a multiple of 5, so no underflow is possible.
- restock is honoured only in IDLE, taking effect at t+1. It is ignored elsewhere.
- sold_out is combinational from the stock registers.

Test Plan:
1. PRICE=150: dollar, then half (credit 100 then 150), sel=2, vend_ready tied 1 -> vend_valid for 1 cycle with vend_item=2, stock[2]=14, credit 0, IDLE, no change_valid.
2. Two dollars (200), sel=0, then change_ready held 0 for 3 cycles and then 1 -> vend, then change_coin=quarter held stable while stalled, then a second quarter, then IDLE with credit 0.
3. Dime, nickel, quarter (40), refund_req -> quarter, dime, nickel in order, credit 15->5->0; a sel_valid during CHANGE is ignored.
4. Credit 200, dollar offered -> coin_reject pulse, credit stays 200. A coin with two bits set -> rejected. sel=N_ITEMS -> sel_err.
5. Vend item 4 fifteen times -> sold_out[4]=1; next sel=4 -> sel_err. restock in IDLE -> stock[4]=15, sold_out=0.
6. Credit 200, vend, and rst_n pulled low during CHANGE -> all outputs 0 and credit 0 immediately. After release, a dollar is credited normally.
